fu_cdb_arbiter: RTL and testbench
=================================

Name: fu_cdb_arbiter

Overview:
Sits between the functional units (ALU×3, MULT×2, BR) and the single common data bus (CDB) feeding complete/ROB/PRF. It holds each FU's finished result in a one-entry slot and grants exactly one slot per cycle to the CDB using round-robin priority. It also produces per-FU busy signals to the RS and a dispatch stall. Together these replace ad-hoc fixed-priority done selection and guarantee no completed result is lost or starved.

Parameters:
NUM_FU, 6, number of FU result sources; index 0..5 = ALU_1, ALU_2, ALU_3, MULT_1, MULT_2, BRANCH
STALL_THRESH, 3, occupied-slot count at or above which stall_dispatch asserts
IDX_W, $clog2(NUM_FU), width of the round-robin pointer

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
fu_valid_in  in  NUM_FU  FU i presents a finished result this cycle
fu_packet_in  in  NUM_FU x FU_COMPLETE_PACKET  result packets, indexed as fu_valid_in
squash  in  1  mispredict flush; discards all held and incoming results
cdb_valid  out  1  CDB carries a result this cycle
cdb_packet  out  FU_COMPLETE_PACKET  granted packet, '0 when cdb_valid=0
cdb_src  out  IDX_W  index of the granted FU, 0 when idle
fu_busy_out  out  NUM_FU  to RS: do not issue to FU i this cycle
stall_dispatch  out  1  to dispatch: occupied slots >= STALL_THRESH
overflow_err  out  1  sticky; a result arrived at an occupied, ungranted slot

Behaviour:
- Reset (async): all slot_valid=0, slot packets='0, rr_ptr=NUM_FU-1 (so index 0 has first priority), overflow_err=0. All outputs are 0 during reset.
- Slot i loads fu_packet_in[i] at posedge when fu_valid_in[i]=1 and the slot is free next cycle (empty, or granted this cycle).
- Minimum latency from fu_valid_in to cdb_valid is 1 cycle. Slots never bypass straight to the CDB.
- Arbitration is combinational over slot_valid. The search starts at (rr_ptr+1) mod NUM_FU, wraps, and the first valid index wins.
- On a grant: cdb_valid=1, cdb_packet=slot[g], cdb_src=g. At posedge, slot g clears (unless reloaded) and rr_ptr<=g. With no grant, rr_ptr holds.
- Starvation bound: an occupied slot is granted within NUM_FU cycles.
- fu_busy_out[i] = slot_valid[i] & ~grant[i], combinational.
- stall_dispatch = popcount(slot_valid) >= STALL_THRESH, combinational.
- Simultaneous grant and arrival on the same i: the slot reloads with the new packet and stays valid.
- Arrival at an occupied, ungranted slot: the old packet is kept, the new one is dropped, and overflow_err sets and stays set until reset.
- squash=1: cdb_valid=0 this cycle. At posedge all slot_valid clear, incoming fu_valid_in is ignored, and rr_ptr is unchanged. squash takes precedence over grant and load.
- Reset mid-operation clears everything immediately. Results in flight are lost by design.

Decomposition:
- sys_defs package: FU_COMPLETE_PACKET (existing), NUM_FU, and an FU index enum (ALU_1..BRANCH) mapped to 0..5.
- Sub-module rr_pick: purely combinational. Inputs are the request vector and pointer; outputs are a one-hot grant, the index, and any_grant. The pointer register stays in fu_cdb_arbiter.

Test Plan:
- Reset, then fu_valid_in=6'b000001 with pr_idx=7 at cycle 1 -> cycle 2: cdb_valid=1, cdb_src=0, pr_idx=7. Cycle 3: cdb_valid=0.
- All six valid in one cycle, pr_idx 10..15 -> grants in cycles 2..7 with cdb_src 0,1,2,3,4,5. stall_dispatch=1 in cycles 2..5 (6,5,4,3 occupied) and 0 from cycle 6.
- Slots 1 and 4 held continuously, re-fed on every grant -> cdb_src alternates 1,4,1,4. Neither is idle for more than 1 cycle.
- Slot 3 held and not granted (slot 0 wins first), fu_valid_in[3] again -> slot 3 keeps its original pr_idx, overflow_err=1 and stays set. fu_busy_out[3]=1 beforehand.
- Slots 0, 2, 5 occupied, squash=1 -> cdb_valid=0 that cycle. Next cycle slot_valid=0 and cdb_valid=0. rr_ptr is unchanged, checked by the next grant order.
- Assert reset while 4 slots are occupied -> outputs go to 0 the same cycle. After release, the first grant goes to index 0.

Source files
------------

// File: rtl/sys_defs.sv
// Shared definitions for the completion path: FU count, FU index names and
// the packet a functional unit hands to the common data bus.
package sys_defs;

    localparam int NUM_FU = 6;
    localparam int IDX_W  = $clog2(NUM_FU);

    // Fixed mapping of FU result sources onto arbiter slot indices.
    typedef enum logic [IDX_W-1:0] {
        ALU_1  = 0,
        ALU_2  = 1,
        ALU_3  = 2,
        MULT_1 = 3,
        MULT_2 = 4,
        BRANCH = 5
    } fu_idx_e;

    // Finished result as broadcast to complete/ROB/PRF.
    typedef struct packed {
        logic [31:0] result;
        logic [5:0]  pr_idx;
        logic [4:0]  rob_idx;
        logic        take_branch;
    } FU_COMPLETE_PACKET;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after the pointer wins,
// searching upward and wrapping. Holds no state.
module rr_pick #(
    parameter int N = 6,
    parameter int W = 3
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    int w_j;

    // Walk ptr+1 .. ptr+N (mod N); the first set request is granted.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        for (int k = 1; k <= N; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= N) w_j = w_j - N;
            if (!o_any && i_req[w_j]) begin
                o_any       = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx       = W'(w_j);
            end
        end
    end

endmodule

// File: rtl/fu_cdb_arbiter.sv
// One-entry result slot per FU, round-robin granted onto the single CDB.
// Also drives per-FU busy back to the RS and a dispatch stall on occupancy.
module fu_cdb_arbiter
    import sys_defs::*;
#(
    parameter int STALL_THRESH = 3
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_FU-1:0]              fu_valid_in,
    input  FU_COMPLETE_PACKET [NUM_FU-1:0] fu_packet_in,
    input  logic                           squash,
    output logic                           cdb_valid,
    output FU_COMPLETE_PACKET              cdb_packet,
    output logic [IDX_W-1:0]               cdb_src,
    output logic [NUM_FU-1:0]              fu_busy_out,
    output logic                           stall_dispatch,
    output logic                           overflow_err
);

    localparam logic [IDX_W:0]   LP_THRESH  = (IDX_W+1)'(STALL_THRESH);
    localparam logic [IDX_W-1:0] LP_PTR_RST = IDX_W'(NUM_FU - 1);

    logic [NUM_FU-1:0]  r_slot_valid;
    FU_COMPLETE_PACKET  r_slot_pkt [NUM_FU];
    logic [IDX_W-1:0]   r_rr_ptr;
    logic               r_overflow;

    logic [NUM_FU-1:0]  w_grant;
    logic [NUM_FU-1:0]  w_gnt_eff;
    logic [NUM_FU-1:0]  w_slot_free;
    logic [IDX_W-1:0]   w_gidx;
    logic               w_any;
    logic               w_cdb_valid;
    logic [IDX_W:0]     w_occ;

    rr_pick #(
        .N (NUM_FU),
        .W (IDX_W)
    ) u_rr_pick (
        .i_req   (r_slot_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    // Squash suppresses the grant entirely; the slot free test uses the
    // effective grant so a squashed cycle never counts as a drain.
    always_comb begin
        w_cdb_valid = w_any & ~squash;
        w_gnt_eff   = squash ? '0 : w_grant;
        w_slot_free = ~r_slot_valid | w_gnt_eff;
    end

    // Occupancy count feeding the dispatch stall.
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < NUM_FU; i++)
            w_occ = w_occ + {{IDX_W{1'b0}}, r_slot_valid[i]};
    end

    // CDB drive: packet and source are forced to zero when nothing is granted.
    always_comb begin
        cdb_valid      = w_cdb_valid;
        cdb_packet     = w_cdb_valid ? r_slot_pkt[w_gidx] : '0;
        cdb_src        = w_cdb_valid ? w_gidx : '0;
        fu_busy_out    = r_slot_valid & ~w_gnt_eff;
        stall_dispatch = (w_occ >= LP_THRESH);
        overflow_err   = r_overflow;
    end

    // Slot fill/drain, pointer advance and sticky overflow. Squash wins over
    // everything: slots empty, arrivals ignored, pointer held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_slot_valid <= '0;
            for (int i = 0; i < NUM_FU; i++)
                r_slot_pkt[i] <= '0;
            r_rr_ptr   <= LP_PTR_RST;
            r_overflow <= 1'b0;
        end else if (squash) begin
            r_slot_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid_in[i] && w_slot_free[i]) begin
                    r_slot_valid[i] <= 1'b1;
                    r_slot_pkt[i]   <= fu_packet_in[i];
                end else if (w_gnt_eff[i]) begin
                    r_slot_valid[i] <= 1'b0;
                end
            end
            if (|(fu_valid_in & ~w_slot_free))
                r_overflow <= 1'b1;
            if (w_any)
                r_rr_ptr <= w_gidx;
        end
    end

endmodule

// File: tb/tb_fu_cdb_arbiter.sv
// Directed bench for fu_cdb_arbiter: inputs change just after the rising
// edge, outputs are sampled on the falling edge.
module tb_fu_cdb_arbiter;
    import sys_defs::*;

    logic                           clock = 1'b0;
    logic                           reset;
    logic [NUM_FU-1:0]              fu_valid_in;
    FU_COMPLETE_PACKET [NUM_FU-1:0] fu_packet_in;
    logic                           squash;
    logic                           cdb_valid;
    FU_COMPLETE_PACKET              cdb_packet;
    logic [IDX_W-1:0]               cdb_src;
    logic [NUM_FU-1:0]              fu_busy_out;
    logic                           stall_dispatch;
    logic                           overflow_err;

    int n_checks = 0;
    int n_pass   = 0;

    fu_cdb_arbiter #(.STALL_THRESH(3)) dut (
        .clock          (clock),
        .reset          (reset),
        .fu_valid_in    (fu_valid_in),
        .fu_packet_in   (fu_packet_in),
        .squash         (squash),
        .cdb_valid      (cdb_valid),
        .cdb_packet     (cdb_packet),
        .cdb_src        (cdb_src),
        .fu_busy_out    (fu_busy_out),
        .stall_dispatch (stall_dispatch),
        .overflow_err   (overflow_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_in();
        fu_valid_in  = '0;
        fu_packet_in = '0;
    endtask

    task automatic set_pkt(input int i, input int pr);
        fu_packet_in[i].pr_idx      = 6'(pr);
        fu_packet_in[i].result      = 32'h1000 + 32'(pr);
        fu_packet_in[i].rob_idx     = 5'(pr);
        fu_packet_in[i].take_branch = 1'b0;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        squash = 1'b0;
        clr_in();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        squash = 1'b0;
        clr_in();
        @(negedge clock);
        n_checks++;
        if ({cdb_valid, cdb_src, fu_busy_out, stall_dispatch, overflow_err} !== '0 || cdb_packet !== '0)
            $display("FAIL reset_outputs: got v=%b src=%0d busy=%b stall=%b ovf=%b pkt=%h, want all 0",
                     cdb_valid, cdb_src, fu_busy_out, stall_dispatch, overflow_err, cdb_packet);
        else n_pass++;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        fu_valid_in = 6'b000001;
        set_pkt(0, 7);
        @(negedge clock);
        n_checks++;
        if (cdb_valid !== 1'b0) $display("FAIL single_no_bypass: cdb_valid=%b want 0", cdb_valid);
        else n_pass++;
        tick();
        clr_in();
        @(negedge clock);
        n_checks++;
        if ({cdb_valid, cdb_src, cdb_packet.pr_idx} !== {1'b1, IDX_W'(0), 6'd7})
            $display("FAIL single_grant: v=%b src=%0d pr=%0d want 1/0/7", cdb_valid, cdb_src, cdb_packet.pr_idx);
        else n_pass++;
        n_checks++;
        if (cdb_packet.result !== 32'h1007) $display("FAIL single_result: got %h want 00001007", cdb_packet.result);
        else n_pass++;
        tick();
        @(negedge clock);
        n_checks++;
        if (cdb_valid !== 1'b0) $display("FAIL single_drained: cdb_valid=%b want 0", cdb_valid);
        else n_pass++;
    endtask

    task automatic test_all_six();
        logic [NUM_FU-1:0] eb;
        do_reset();
        fu_valid_in = '1;
        for (int i = 0; i < NUM_FU; i++) set_pkt(i, 10 + i);
        tick();
        clr_in();
        for (int k = 0; k < NUM_FU; k++) begin
            eb = '0;
            for (int j = k + 1; j < NUM_FU; j++) eb[j] = 1'b1;
            @(negedge clock);
            n_checks++;
            if ({cdb_valid, cdb_src, cdb_packet.pr_idx} !== {1'b1, IDX_W'(k), 6'(10 + k)})
                $display("FAIL all6_grant[%0d]: v=%b src=%0d pr=%0d want 1/%0d/%0d",
                         k, cdb_valid, cdb_src, cdb_packet.pr_idx, k, 10 + k);
            else n_pass++;
            n_checks++;
            if (stall_dispatch !== (k <= 3))
                $display("FAIL all6_stall[%0d]: got %b want %b", k, stall_dispatch, (k <= 3));
            else n_pass++;
            n_checks++;
            if (fu_busy_out !== eb)
                $display("FAIL all6_busy[%0d]: got %b want %b", k, fu_busy_out, eb);
            else n_pass++;
            tick();
        end
        @(negedge clock);
        n_checks++;
        if ({cdb_valid, stall_dispatch} !== 2'b00)
            $display("FAIL all6_empty: v=%b stall=%b want 0/0", cdb_valid, stall_dispatch);
        else n_pass++;
    endtask

    task automatic test_alternate();
        int e1, e4, g, ep, np;
        do_reset();
        fu_valid_in = 6'b010010;
        set_pkt(int'(ALU_2), 20);
        set_pkt(int'(MULT_2), 40);
        e1 = 20;
        e4 = 40;
        tick();
        clr_in();
        for (int n = 0; n < 6; n++) begin
            g  = (n % 2 == 0) ? int'(ALU_2) : int'(MULT_2);
            ep = (g == 1) ? e1 : e4;
            np = (g == 1) ? 21 + n : 41 + n;
            fu_valid_in[g] = 1'b1;
            set_pkt(g, np);
            @(negedge clock);
            n_checks++;
            if ({cdb_valid, cdb_src, cdb_packet.pr_idx} !== {1'b1, IDX_W'(g), 6'(ep)})
                $display("FAIL alt_grant[%0d]: v=%b src=%0d pr=%0d want 1/%0d/%0d",
                         n, cdb_valid, cdb_src, cdb_packet.pr_idx, g, ep);
            else n_pass++;
            n_checks++;
            if (fu_busy_out !== ((g == 1) ? 6'b010000 : 6'b000010))
                $display("FAIL alt_busy[%0d]: got %b", n, fu_busy_out);
            else n_pass++;
            if (g == 1) e1 = np; else e4 = np;
            tick();
            clr_in();
        end
        n_checks++;
        if (overflow_err !== 1'b0) $display("FAIL alt_no_overflow: got %b want 0", overflow_err);
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        fu_valid_in = 6'b001001;
        set_pkt(0, 50);
        set_pkt(3, 53);
        tick();
        clr_in();
        fu_valid_in[3] = 1'b1;
        set_pkt(3, 99);
        @(negedge clock);
        n_checks++;
        if ({cdb_valid, cdb_src, cdb_packet.pr_idx} !== {1'b1, IDX_W'(0), 6'd50})
            $display("FAIL ovf_first_grant: v=%b src=%0d pr=%0d want 1/0/50", cdb_valid, cdb_src, cdb_packet.pr_idx);
        else n_pass++;
        n_checks++;
        if ({fu_busy_out, overflow_err} !== {6'b001000, 1'b0})
            $display("FAIL ovf_busy_before: busy=%b ovf=%b want 001000/0", fu_busy_out, overflow_err);
        else n_pass++;
        tick();
        clr_in();
        @(negedge clock);
        n_checks++;
        if ({cdb_valid, cdb_src, cdb_packet.pr_idx, overflow_err} !== {1'b1, IDX_W'(3), 6'd53, 1'b1})
            $display("FAIL ovf_keep_old: v=%b src=%0d pr=%0d ovf=%b want 1/3/53/1",
                     cdb_valid, cdb_src, cdb_packet.pr_idx, overflow_err);
        else n_pass++;
        repeat (3) tick();
        @(negedge clock);
        n_checks++;
        if ({cdb_valid, overflow_err} !== 2'b01)
            $display("FAIL ovf_sticky: v=%b ovf=%b want 0/1", cdb_valid, overflow_err);
        else n_pass++;
    endtask

    task automatic test_squash();
        do_reset();
        fu_valid_in = 6'b100101;
        set_pkt(0, 60);
        set_pkt(2, 62);
        set_pkt(5, 65);
        tick();
        clr_in();
        squash      = 1'b1;
        fu_valid_in = '1;
        for (int i = 0; i < NUM_FU; i++) set_pkt(i, 30 + i);
        @(negedge clock);
        n_checks++;
        if (cdb_valid !== 1'b0 || cdb_src !== '0 || cdb_packet !== '0)
            $display("FAIL squash_cycle: v=%b src=%0d pkt=%h want 0/0/0", cdb_valid, cdb_src, cdb_packet);
        else n_pass++;
        tick();
        squash = 1'b0;
        clr_in();
        fu_valid_in = 6'b000101;
        set_pkt(0, 70);
        set_pkt(2, 72);
        @(negedge clock);
        n_checks++;
        if ({cdb_valid, fu_busy_out, stall_dispatch} !== '0)
            $display("FAIL squash_cleared: v=%b busy=%b stall=%b want all 0", cdb_valid, fu_busy_out, stall_dispatch);
        else n_pass++;
        tick();
        clr_in();
        @(negedge clock);
        n_checks++;
        if ({cdb_valid, cdb_src, cdb_packet.pr_idx} !== {1'b1, IDX_W'(0), 6'd70})
            $display("FAIL squash_ptr_held_a: v=%b src=%0d pr=%0d want 1/0/70", cdb_valid, cdb_src, cdb_packet.pr_idx);
        else n_pass++;
        tick();
        @(negedge clock);
        n_checks++;
        if ({cdb_valid, cdb_src, cdb_packet.pr_idx} !== {1'b1, IDX_W'(2), 6'd72})
            $display("FAIL squash_ptr_held_b: v=%b src=%0d pr=%0d want 1/2/72", cdb_valid, cdb_src, cdb_packet.pr_idx);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        fu_valid_in = 6'b011110;
        for (int i = 1; i <= 4; i++) set_pkt(i, 70 + i);
        tick();
        clr_in();
        @(negedge clock);
        n_checks++;
        if ({cdb_valid, cdb_src, cdb_packet.pr_idx, stall_dispatch} !== {1'b1, IDX_W'(1), 6'd71, 1'b1})
            $display("FAIL rstmid_pre: v=%b src=%0d pr=%0d stall=%b want 1/1/71/1",
                     cdb_valid, cdb_src, cdb_packet.pr_idx, stall_dispatch);
        else n_pass++;
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({cdb_valid, cdb_src, fu_busy_out, stall_dispatch, overflow_err} !== '0 || cdb_packet !== '0)
            $display("FAIL rstmid_async: v=%b src=%0d busy=%b stall=%b ovf=%b want all 0",
                     cdb_valid, cdb_src, fu_busy_out, stall_dispatch, overflow_err);
        else n_pass++;
        @(negedge clock);
        reset       = 1'b0;
        fu_valid_in = 6'b001001;
        set_pkt(0, 80);
        set_pkt(3, 83);
        tick();
        clr_in();
        @(negedge clock);
        n_checks++;
        if ({cdb_valid, cdb_src, cdb_packet.pr_idx} !== {1'b1, IDX_W'(0), 6'd80})
            $display("FAIL rstmid_first_grant: v=%b src=%0d pr=%0d want 1/0/80", cdb_valid, cdb_src, cdb_packet.pr_idx);
        else n_pass++;
    endtask

    initial begin
        reset  = 1'b1;
        squash = 1'b0;
        clr_in();
        test_reset();
        test_single();
        test_all_six();
        test_alternate();
        test_overflow();
        test_squash();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
